// File: rtl/difftest_commit_packer_pkg.sv
// Shared difftest types: commit record layout (matches the checker/DPI side),
// packer state encoding and the default end-of-simulation encoding.
package difftest_commit_packer_pkg;

   typedef struct packed {
      logic        commit;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        wen;
      logic [4:0]  wdest;
      logic [31:0] wdata;
      logic        skip;
   } difftest_info_t;

   typedef enum logic [1:0] {RUN, HALT, TIMEOUT} state_t;

   localparam logic [31:0] TRAP_INSTR_DEFAULT = 32'h00100073;

   // x0 is hard-wired, so a write to it carries no architectural effect
   function automatic difftest_info_t sanitize(input difftest_info_t rec);
      difftest_info_t res;
      res = rec;
      if (rec.wen && rec.wdest == 5'd0) begin
         res.wen   = 1'b0;
         res.wdata = '0;
      end
      return res;
   endfunction

endpackage

// File: rtl/difftest_lane_compact.sv
// Combinational lane compactor: k-th surviving lane lands in slot k, records sanitised.
// Zero latency, no flow control; drop[i] removes lane i before compaction.
module difftest_lane_compact
   import difftest_commit_packer_pkg::*;
#(
   parameter int NR_COMMIT_PORTS = 2,
   localparam int CW = $clog2(NR_COMMIT_PORTS + 1)
) (
   input  difftest_info_t             lanes     [NR_COMMIT_PORTS],
   input  logic [NR_COMMIT_PORTS-1:0] drop,
   output difftest_info_t             out_lanes [NR_COMMIT_PORTS],
   output logic [CW-1:0]              count
);

   logic [NR_COMMIT_PORTS-1:0] emit;
   logic [CW-1:0]              pos [NR_COMMIT_PORTS];

   always_comb begin
      count = '0;
      emit  = '0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         emit[i] = lanes[i].commit & ~drop[i];
         pos[i]  = count;
         if (emit[i]) count = count + CW'(1);
      end
      // Select by destination slot so no variable-index write is needed
      for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
         out_lanes[j] = '0;
         for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (emit[i] && pos[i] == CW'(j)) out_lanes[j] = sanitize(lanes[i]);
         end
      end
   end

endmodule

// File: rtl/difftest_commit_packer.sv
// Packs retire lanes into the checker's commit vector and tracks trap/watchdog end of simulation.
// One cycle retire_info -> diff_info; never stalls the core, consumer samples every cycle.
module difftest_commit_packer
   import difftest_commit_packer_pkg::*;
#(
   parameter int          NR_COMMIT_PORTS = 2,
   parameter int          TIMEOUT_CYCLES  = 10000,
   parameter logic [31:0] TRAP_INSTR      = TRAP_INSTR_DEFAULT
) (
   input  logic           clock,
   input  logic           reset_n,
   input  difftest_info_t retire_info [NR_COMMIT_PORTS],
   input  logic [31:0]    trap_a0,
   output difftest_info_t diff_info   [NR_COMMIT_PORTS],
   output logic           halt,
   output logic           good_trap,
   output logic           timeout,
   output logic [63:0]    inst_count
);

   localparam int CW = $clog2(NR_COMMIT_PORTS + 1);
   localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t                     state, state_nxt;
   logic [WW-1:0]              wd_cnt, wd_nxt;
   logic [NR_COMMIT_PORTS-1:0] is_trap, drop;
   logic                       any_valid, trap_any, run;
   difftest_info_t             cmp_lanes [NR_COMMIT_PORTS];
   logic [CW-1:0]              cmp_count;

   // Everything younger than the oldest trap lane is discarded
   always_comb begin
      is_trap   = '0;
      drop      = '0;
      any_valid = 1'b0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         is_trap[i] = retire_info[i].commit && (retire_info[i].instr == TRAP_INSTR);
         any_valid  = any_valid | retire_info[i].commit;
         if (i > 0) drop[i] = drop[i-1] | is_trap[i-1];
      end
      trap_any = |is_trap;
   end

   difftest_lane_compact #(.NR_COMMIT_PORTS(NR_COMMIT_PORTS)) u_compact (
      .lanes     (retire_info),
      .drop      (drop),
      .out_lanes (cmp_lanes),
      .count     (cmp_count)
   );

   assign run = (state == RUN);

   always_comb begin
      state_nxt = state;
      wd_nxt    = wd_cnt;
      case (state)
         RUN: begin
            if (trap_any)                                state_nxt = HALT;
            else if (any_valid)                          wd_nxt    = '0;
            else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1))  state_nxt = TIMEOUT;
            else                                         wd_nxt    = wd_cnt + WW'(1);
         end
         default: begin
            state_nxt = state;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         wd_cnt     <= '0;
         good_trap  <= 1'b0;
         inst_count <= '0;
         for (int i = 0; i < NR_COMMIT_PORTS; i++) diff_info[i] <= '0;
      end else begin
         state  <= state_nxt;
         wd_cnt <= wd_nxt;
         for (int i = 0; i < NR_COMMIT_PORTS; i++) diff_info[i] <= run ? cmp_lanes[i] : '0;
         if (run) inst_count <= inst_count + 64'(cmp_count);
         if (run && trap_any) good_trap <= (trap_a0 == 32'd0);
      end
   end

   assign halt    = (state == HALT);
   assign timeout = (state == TIMEOUT);

endmodule

// File: tb/tb_difftest_commit_packer.sv
// Self-checking bench for difftest_commit_packer: directed table, corner sequences, random vs model.
module tb_difftest_commit_packer;
   import difftest_commit_packer_pkg::*;

   localparam int          NP  = 2;
   localparam int          TMO = 8;
   localparam logic [31:0] EBR = 32'h00100073;
   localparam logic [31:0] NOP = 32'h00000013;

   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   difftest_info_t retire_info [NP];
   logic [31:0]    trap_a0;
   difftest_info_t diff_info [NP];
   logic           halt, good_trap, timeout;
   logic [63:0]    inst_count;

   int n_checks = 0;
   int n_pass   = 0;

   difftest_commit_packer #(.NR_COMMIT_PORTS(NP), .TIMEOUT_CYCLES(TMO)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .retire_info (retire_info),
      .trap_a0     (trap_a0),
      .diff_info   (diff_info),
      .halt        (halt),
      .good_trap   (good_trap),
      .timeout     (timeout),
      .inst_count  (inst_count)
   );

   always #5 clock = ~clock;

   function automatic difftest_info_t mk(input logic c, input logic [31:0] pc, input logic [31:0] ins,
                                         input logic wen, input logic [4:0] wd, input logic [31:0] wdat,
                                         input logic skip);
      difftest_info_t r;
      r.commit = c; r.pc = pc; r.instr = ins; r.wen = wen;
      r.wdest = wd; r.wdata = wdat; r.skip = skip;
      return r;
   endfunction

   task automatic check_info(input string name, input difftest_info_t act, input difftest_info_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input difftest_info_t a, input difftest_info_t b, input logic [31:0] a0);
      retire_info[0] = a;
      retire_info[1] = b;
      trap_a0        = a0;
   endtask

   // ---------------- reference model: list of emitted records per cycle ----------------
   difftest_info_t m_exp [NP];
   logic [63:0]    m_cnt;
   bit             m_halt, m_good, m_to;
   int             m_idle;

   task automatic model_reset();
      m_cnt = '0; m_halt = 0; m_good = 0; m_to = 0; m_idle = 0;
      for (int i = 0; i < NP; i++) m_exp[i] = '0;
   endtask

   task automatic model_step(input difftest_info_t a, input difftest_info_t b, input logic [31:0] a0);
      difftest_info_t q[$];
      difftest_info_t ins [NP];
      difftest_info_t r;
      bit trap = 0;
      bit any  = 0;
      ins[0] = a; ins[1] = b;
      for (int i = 0; i < NP; i++) m_exp[i] = '0;
      if (!m_halt && !m_to) begin
         for (int i = 0; i < NP; i++) begin
            if (ins[i].commit) begin
               any = 1;
               if (!trap) begin
                  r = ins[i];
                  if (r.wen && r.wdest == 0) begin r.wen = 0; r.wdata = 0; end
                  q.push_back(r);
                  if (ins[i].instr == EBR) trap = 1;
               end
            end
         end
         for (int k = 0; k < q.size(); k++) m_exp[k] = q[k];
         m_cnt = m_cnt + 64'(q.size());
         if (trap) begin
            m_halt = 1;
            m_good = (a0 == 0);
         end else if (any) m_idle = 0;
         else begin
            m_idle++;
            if (m_idle == TMO) m_to = 1;
         end
      end
   endtask

   task automatic run_cycle(input difftest_info_t a, input difftest_info_t b, input logic [31:0] a0,
                            input string tag);
      drive(a, b, a0);
      model_step(a, b, a0);
      step();
      check_info({tag, "_d0"}, diff_info[0], m_exp[0]);
      check_info({tag, "_d1"}, diff_info[1], m_exp[1]);
      check_val({tag, "_cnt"}, inst_count, m_cnt);
      check_val({tag, "_halt"}, halt, m_halt);
      check_val({tag, "_good"}, good_trap, m_good);
      check_val({tag, "_tmo"}, timeout, m_to);
   endtask

   task automatic apply_reset();
      drive('0, '0, 32'd1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit             rst;
      difftest_info_t in0, in1;
      logic [31:0]    a0;
      difftest_info_t e0, e1;
      int             inc;
      bit             eh, eg;
   } vec_t;

   vec_t           tbl [8];
   logic [63:0]    exp_total;
   difftest_info_t idle_l, one_l;
   int             idle_pct [4];

   initial begin
      tbl[0] = '{1, mk(0,0,0,0,0,0,0), mk(1,32'h80000004,NOP,1,3,32'hAA,0), 32'd1,
                 mk(1,32'h80000004,NOP,1,3,32'hAA,0), '0, 1, 0, 0};
      tbl[1] = '{0, mk(1,32'h80000000,NOP,1,0,32'h55,0), mk(1,32'h80000004,NOP,1,7,32'h77,1), 32'd1,
                 mk(1,32'h80000000,NOP,0,0,0,0), mk(1,32'h80000004,NOP,1,7,32'h77,1), 2, 0, 0};
      tbl[2] = '{0, mk(1,32'h80000008,NOP,0,9,32'h99,1), '0, 32'd1,
                 mk(1,32'h80000008,NOP,0,9,32'h99,1), '0, 1, 0, 0};
      tbl[3] = '{0, '0, '0, 32'd0, '0, '0, 0, 0, 0};
      tbl[4] = '{0, mk(1,32'h8000000c,EBR,0,0,0,0), mk(1,32'h80000010,NOP,1,1,1,0), 32'd0,
                 mk(1,32'h8000000c,EBR,0,0,0,0), '0, 1, 1, 1};
      tbl[5] = '{0, mk(1,32'h80000014,NOP,0,0,0,0), mk(1,32'h80000018,NOP,0,0,0,0), 32'd1,
                 '0, '0, 0, 1, 1};
      tbl[6] = '{1, mk(1,32'h80000000,NOP,1,2,32'h22,0), mk(1,32'h80000004,EBR,0,0,0,0), 32'd1,
                 mk(1,32'h80000000,NOP,1,2,32'h22,0), mk(1,32'h80000004,EBR,0,0,0,0), 2, 1, 0};
      tbl[7] = '{0, mk(1,32'h80000008,EBR,0,0,0,0), '0, 32'd0, '0, '0, 0, 1, 0};
      idle_pct = '{10, 50, 85, 100};
      idle_l   = '0;
      one_l    = mk(1, 32'h80000000, NOP, 1, 5, 32'h5, 0);

      // reset state, sampled while reset is held
      drive('0, '0, 32'd1);
      #2;
      check_info("rst_d0", diff_info[0], '0);
      check_info("rst_d1", diff_info[1], '0);
      check_val("rst_cnt", inst_count, 64'd0);
      check_val("rst_flags", {halt, good_trap, timeout}, 64'd0);
      step();
      reset_n = 1'b1;

      // directed table
      exp_total = '0;
      for (int v = 0; v < 8; v++) begin
         if (tbl[v].rst) begin
            apply_reset();
            exp_total = '0;
         end
         drive(tbl[v].in0, tbl[v].in1, tbl[v].a0);
         step();
         exp_total = exp_total + 64'(tbl[v].inc);
         check_info($sformatf("vec%0d_d0", v), diff_info[0], tbl[v].e0);
         check_info($sformatf("vec%0d_d1", v), diff_info[1], tbl[v].e1);
         check_val($sformatf("vec%0d_cnt", v), inst_count, exp_total);
         check_val($sformatf("vec%0d_halt", v), halt, 64'(tbl[v].eh));
         check_val($sformatf("vec%0d_good", v), good_trap, 64'(tbl[v].eg));
         check_val($sformatf("vec%0d_tmo", v), timeout, 64'd0);
      end

      // asynchronous reset in the middle of a run
      apply_reset();
      for (int i = 0; i < 5; i++) run_cycle(one_l, idle_l, 32'd1, "pre_rst");
      check_val("pre_rst_total", inst_count, 64'd5);
      #2;
      reset_n = 1'b0;
      #1;
      check_info("async_rst_d0", diff_info[0], '0);
      check_val("async_rst_cnt", inst_count, 64'd0);
      step();
      reset_n = 1'b1;
      model_reset();
      run_cycle(one_l, idle_l, 32'd1, "post_rst");
      check_val("post_rst_total", inst_count, 64'd1);

      // watchdog: 7 idle then a commit survives, then 8 idle expires
      apply_reset();
      for (int i = 0; i < TMO - 1; i++) run_cycle(idle_l, idle_l, 32'd1, "wd_idle7");
      run_cycle(one_l, idle_l, 32'd1, "wd_commit");
      check_val("wd_no_timeout", timeout, 64'd0);
      for (int i = 0; i < TMO - 1; i++) run_cycle(idle_l, idle_l, 32'd1, "wd_idle");
      check_val("wd_before_expire", timeout, 64'd0);
      run_cycle(idle_l, idle_l, 32'd1, "wd_expire");
      check_val("wd_expired", timeout, 64'd1);
      run_cycle(one_l, one_l, 32'd1, "wd_frozen");
      check_val("wd_frozen_commit", diff_info[0].commit, 64'd0);
      check_val("wd_frozen_cnt", inst_count, 64'd1);

      // trap at the watchdog boundary wins
      apply_reset();
      for (int i = 0; i < TMO - 1; i++) run_cycle(idle_l, idle_l, 32'd1, "tb_idle");
      run_cycle(mk(1, 32'h80000100, EBR, 0, 0, 0, 0), idle_l, 32'd0, "tb_trap");
      check_val("tb_halt", halt, 64'd1);
      check_val("tb_timeout", timeout, 64'd0);
      for (int i = 0; i < TMO + 2; i++) run_cycle(idle_l, idle_l, 32'd1, "tb_after");
      check_val("tb_timeout_after", timeout, 64'd0);

      // randomized episodes against the model
      for (int ep = 0; ep < 16; ep++) begin
         apply_reset();
         for (int c = 0; c < 40; c++) begin
            difftest_info_t l [NP];
            for (int i = 0; i < NP; i++) begin
               l[i].commit = ($urandom_range(99) >= idle_pct[ep % 4]);
               l[i].pc     = $urandom;
               l[i].instr  = ($urandom_range(29) == 0) ? EBR : $urandom;
               l[i].wen    = 1'($urandom_range(1));
               l[i].wdest  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
               l[i].wdata  = $urandom;
               l[i].skip   = 1'($urandom_range(1));
            end
            run_cycle(l[0], l[1], 32'($urandom_range(1)), $sformatf("rnd%0d_%0d", ep, c));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
